// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width codes, and the legality / lane-placement rules used at accept time.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_RESP = 2'd2,
    RESPOND   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      LSU_H, LSU_HU: return addr[0];
      LSU_W:         return addr != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic lsu_legal(input logic write, input logic [2:0] funct3);
    case (funct3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return ~write;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_lane_be(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      LSU_B, LSU_BU: return 4'b0001 << addr;
      LSU_H, LSU_HU: return 4'b0011 << {addr[1], 1'b0};
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_lane_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      LSU_B, LSU_BU: return {4{wdata[7:0]}};
      LSU_H, LSU_HU: return {2{wdata[15:0]}};
      default:       return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// to 32 bits according to the load's width/sign code.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
    case (funct3_i)
      LSU_B:   data_o = {{24{byte_v[7]}}, byte_v};
      LSU_H:   data_o = {{16{half_v[15]}}, half_v};
      LSU_W:   data_o = rdata_i;
      LSU_BU:  data_o = {24'b0, byte_v};
      LSU_HU:  data_o = {16'b0, half_v};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with req/gnt/rvalid memory handshake.
//   state     | meaning
//   IDLE      | ready for a new access
//   REQUEST   | mem_req high, waiting for mem_gnt
//   WAIT_RESP | granted, waiting for mem_rvalid
//   RESPOND   | one-cycle resp_valid pulse (data or error)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout;
  logic [31:0]       align_data;

  load_align u_align (
    .funct3_i (funct3_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (mem_rdata),
    .data_o   (align_data)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    timeout  = TIMEOUT_EN && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_address;
          be_d     = lsu_lane_be(req_funct3, req_address[1:0]);
          wdata_d  = lsu_lane_wdata(req_funct3, req_wdata);
          cnt_d    = '0;
          rdata_d  = '0;
          if (lsu_legal(req_write, req_funct3) && !lsu_misaligned(req_funct3, req_address[1:0])) begin
            state_d = REQUEST;
            err_d   = 1'b0;
          end else begin
            state_d = RESPOND;
            err_d   = 1'b1;
          end
        end
      end
      REQUEST: begin
        cnt_d = cnt_q + 1'b1;
        // A grant landing on the last allowed cycle still counts as timed out.
        if (timeout) begin
          state_d = RESPOND;
          err_d   = 1'b1;
        end else if (mem_gnt) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = RESPOND;
          rdata_d = write_q ? 32'b0 : align_data;
        end else if (timeout) begin
          state_d = RESPOND;
          err_d   = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign mem_req    = (state_q == REQUEST);
  assign mem_we     = mem_req && write_q;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_be     = mem_req ? be_q : 4'b0;
  assign mem_wdata  = mem_req ? wdata_q : 32'b0;
  assign resp_valid = (state_q == RESPOND);
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;
  assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: hand table, randomized accesses against an
// arithmetic reference model, timeout and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        rv_a, rv_b;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_error, a_mem_req, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_resp_valid, b_resp_error, b_mem_req, b_mem_we;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(a_req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_error(a_resp_error), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(b_req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_error(b_resp_error), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] mrd;
    int        gd;
    int        rd;
    bit        e_err;
    bit [3:0]  e_be;
    bit [31:0] e_wd;
    bit [31:0] e_rd;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Reference: derive size/sign/legality from the code, then do plain arithmetic.
  function automatic void model(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, input bit [31:0] mrd,
                                output bit err, output bit [3:0] be,
                                output bit [31:0] mwd, output bit [31:0] rdv);
    int size, off;
    bit uns, legal;
    longint v;
    size = 0; uns = 0; legal = 1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; legal = !wr; end
      3'd5: begin size = 2; uns = 1; legal = !wr; end
      default: legal = 0;
    endcase
    off = int'(a % 32'd4);
    err = !legal || (size > 0 && (int'(a % 32'd4) % size) != 0);
    be  = 4'(((1 << size) - 1) << off);
    if (size == 1)      mwd = 32'(wd[7:0]) * 32'h01010101;
    else if (size == 2) mwd = 32'(wd[15:0]) * 32'h00010001;
    else                mwd = wd;
    rdv = 32'd0;
    if (!err && !wr) begin
      v = (longint'(mrd) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
      if (!uns && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      rdv = 32'(v);
    end
  endfunction

  // Entered and left at posedge+1 with the DUT idle. gd = cycles gnt is
  // withheld, rd = extra cycles after the first WAIT_RESP cycle before rvalid.
  task automatic run_access(input string nm, input vec_t v);
    int  req_cycles = 0;
    int  wait_cnt = 0;
    int  lat = 0;
    bit  granted = 0;
    bit  quiet = 1;
    chk({nm, " ready"}, 32'(a_req_ready), 32'd1);
    rv_a = 1'b1;
    req_write = v.wr; req_funct3 = v.f3; req_address = v.a; req_wdata = v.wd;
    @(posedge clk); #1;
    rv_a = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom); req_address = $urandom; req_wdata = $urandom;
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (granted) begin
        if (wait_cnt == v.rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.mrd;
        end
        wait_cnt++;
      end
      if (a_mem_req) begin
        if (req_cycles == v.gd) mem_gnt = 1'b1;
        req_cycles++;
        chk({nm, " mem_addr"}, a_mem_addr, v.a & 32'hFFFF_FFFC);
        chk({nm, " mem_be"}, 32'(a_mem_be), 32'(v.e_be));
        chk({nm, " mem_we"}, 32'(a_mem_we), 32'(v.wr));
        if (v.wr) chk({nm, " mem_wdata"}, a_mem_wdata, v.e_wd);
      end
      @(negedge clk);
      if (a_resp_valid) lat = cyc;
      else if (a_resp_rdata != 32'd0 || a_resp_error) quiet = 0;
      @(posedge clk); #1;
      if (mem_gnt) granted = 1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL %s no resp_valid within budget actual=none required=pulse", nm);
    end else begin
      chk({nm, " latency"}, 32'(lat), v.e_err ? 32'd1 : 32'(3 + v.gd + v.rd));
    end
    chk({nm, " req_cycles"}, 32'(req_cycles), v.e_err ? 32'd0 : 32'(v.gd + 1));
    chk({nm, " quiet_outputs"}, 32'(quiet), 32'd1);
    chk({nm, " pulse_one_cycle"}, 32'(a_resp_valid), 32'd0);
    chk({nm, " ready_after"}, 32'(a_req_ready), 32'd1);
  endtask

  // Captures the response values seen inside run_access.
  logic        cap_err;
  logic [31:0] cap_rdata;
  always @(negedge clk) if (a_resp_valid) begin
    cap_err   <= a_resp_error;
    cap_rdata <= a_resp_rdata;
  end

  task automatic access_and_check(input string nm, input vec_t v);
    cap_err = 1'bx; cap_rdata = 32'hx;
    run_access(nm, v);
    chk({nm, " resp_error"}, 32'(cap_err), 32'(v.e_err));
    chk({nm, " resp_rdata"}, cap_rdata, v.e_rd);
  endtask

  initial begin
    vec_t v;
    int   lat, cnt;

    rv_a = 0; rv_b = 0; req_write = 0; req_funct3 = 0; req_address = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    reset = 1'b1;

    //            wr f3      addr          wdata         mrdata        gd rd err be     e_wdata       e_rdata
    tbl[0]  = '{1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0,        0, 0, 0, 4'h8, 32'hA5A5_A5A5, 32'h0};
    tbl[2]  = '{0, 3'b000, 32'h0000_0013, 32'h0,         32'hA500_0000, 0, 0, 0, 4'h8, 32'h0,         32'hFFFF_FFA5};
    tbl[3]  = '{0, 3'b100, 32'h0000_0013, 32'h0,         32'hA500_0000, 0, 0, 0, 4'h8, 32'h0,         32'h0000_00A5};
    tbl[4]  = '{0, 3'b001, 32'h0000_0022, 32'h0,         32'h8001_1234, 0, 0, 0, 4'hC, 32'h0,         32'hFFFF_8001};
    tbl[5]  = '{0, 3'b101, 32'h0000_0022, 32'h0,         32'h8001_1234, 0, 0, 0, 4'hC, 32'h0,         32'h0000_8001};
    tbl[6]  = '{0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};
    tbl[7]  = '{0, 3'b011, 32'h0000_0008, 32'h0,         32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};
    tbl[8]  = '{1, 3'b010, 32'h0000_0100, 32'h0123_4567, 32'h0,        3, 1, 0, 4'hF, 32'h0123_4567, 32'h0};
    tbl[9]  = '{0, 3'b010, 32'h0000_0104, 32'h0,         32'h1234_5678, 1, 2, 0, 4'hF, 32'h0,         32'h1234_5678};
    tbl[10] = '{1, 3'b100, 32'h0000_0000, 32'h0000_0011, 32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};
    tbl[11] = '{1, 3'b001, 32'h0000_0021, 32'h0000_1234, 32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};
    tbl[12] = '{0, 3'b000, 32'h0000_0011, 32'h0,         32'h0000_7F00, 0, 0, 0, 4'h2, 32'h0,         32'h0000_007F};
    tbl[13] = '{0, 3'b001, 32'h0000_0020, 32'h0,         32'h1234_F00F, 2, 0, 0, 4'h3, 32'h0,         32'hFFFF_F00F};
    tbl[14] = '{1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 32'h0,        0, 3, 0, 4'hC, 32'hBEEF_BEEF, 32'h0};
    tbl[15] = '{0, 3'b101, 32'h0000_0023, 32'h0,         32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};
    tbl[16] = '{0, 3'b110, 32'h0000_0040, 32'h0,         32'h0,        0, 0, 1, 4'h0, 32'h0,         32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(a_req_ready), 32'd0);
    chk("rst resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst resp_error", 32'(a_resp_error), 32'd0);
    chk("rst resp_rdata", a_resp_rdata, 32'd0);
    chk("rst mem_req", 32'(a_mem_req), 32'd0);
    chk("rst mem_we", 32'(a_mem_we), 32'd0);
    chk("rst mem_be", 32'(a_mem_be), 32'd0);
    chk("rst mem_addr", a_mem_addr, 32'd0);
    chk("rst mem_wdata", a_mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst req_ready", 32'(a_req_ready), 32'd1);

    for (int i = 0; i < 17; i++) access_and_check($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 80; i++) begin
      v.wr  = 1'($urandom);
      v.f3  = 3'($urandom_range(0, 7));
      v.a   = $urandom;
      v.wd  = $urandom;
      v.mrd = $urandom;
      v.gd  = $urandom_range(0, 3);
      v.rd  = $urandom_range(0, 3);
      model(v.wr, v.f3, v.a, v.wd, v.mrd, v.e_err, v.e_be, v.e_wd, v.e_rd);
      access_and_check($sformatf("rnd%0d", i), v);
    end

    // Timeout on the TIMEOUT_CYCLES=4 instance: gnt never arrives.
    rv_b = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h40;
    @(posedge clk); #1;
    rv_b = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    lat = 0; cnt = 0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      if (b_mem_req) cnt++;
      @(negedge clk);
      if (b_resp_valid) begin
        lat = cyc;
        chk("to resp_error", 32'(b_resp_error), 32'd1);
        chk("to resp_rdata", b_resp_rdata, 32'd0);
        chk("to mem_req_dropped", 32'(b_mem_req), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk("to latency", 32'(lat), 32'd5);
    chk("to mem_req_cycles", 32'(cnt), 32'd4);
    chk("to ready_after", 32'(b_req_ready), 32'd1);

    // Reset while in WAIT_RESP, with a response arriving on the reset edge.
    rv_a = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h80;
    @(posedge clk); #1;
    rv_a = 1'b0;
    chk("rstmid mem_req", 32'(a_mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstmid wait mem_req", 32'(a_mem_req), 32'd0);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rstmid ready_in_reset", 32'(a_req_ready), 32'd0);
    chk("rstmid mem_req_after", 32'(a_mem_req), 32'd0);
    chk("rstmid no_resp", 32'(a_resp_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid ready_after", 32'(a_req_ready), 32'd1);
    chk("rstmid no_resp2", 32'(a_resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rstmid no_resp3", 32'(a_resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
